// File: rtl/i2c_slave_regfile_if.sv
// Open-drain I2C bus between one initiator and the regfile target.
// The target only ever pulls SDA low; the wired-AND below stands in for the pull-up.
interface i2c_slave_regfile_if;
  logic I2C_SCLK;
  logic sda_master;
  logic sda_pull;
  logic I2C_SDAT;

  // Resolved bus level: high unless either side pulls low.
  assign I2C_SDAT = sda_master & ~sda_pull;

  modport slave (
    input  I2C_SCLK,
    input  I2C_SDAT,
    output sda_pull
  );

  modport master (
    output I2C_SCLK,
    output sda_master,
    input  I2C_SDAT
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C/SCCB target holding a DEPTH x 8 register file with an auto-incrementing pointer,
// plus a registered fabric read port and a write-commit strobe.
module i2c_slave_regfile #(
  parameter logic [7:0] SLAVE_ADDRESS = 8'h42,
  parameter int         ADDR_W        = 4,
  parameter int         FILTER_LEN    = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  i2c_slave_regfile_if.slave    bus,
  input  logic [ADDR_W-1:0]     REG_ADDR,
  output logic [7:0]            REG_DATA,
  output logic                  WR_STROBE,
  output logic [ADDR_W-1:0]     WR_ADDR,
  output logic [7:0]            WR_DATA,
  output logic                  flagBusy,
  output logic [2:0]            dbg_state_o
);
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REG_IDX, S_WRITE_DATA, S_READ_DATA, S_IGNORE
  } state_e;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] line_raw;
  logic [1:0] sync1_q, sync2_q, filt_q, prev_q;
  logic [3:0] cnt_q [2];

  assign line_raw = {bus.I2C_SDAT, bus.I2C_SCLK};

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= line_raw;
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      // A new level is accepted only after FILTER_LEN consecutive differing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  =  filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] &  prev_q[0];
  assign sda_rise  =  filt_q[1] & ~prev_q[1];
  assign sda_fall  = ~filt_q[1] &  prev_q[1];
  assign start_det = sda_fall & filt_q[0];
  assign stop_det  = sda_rise & filt_q[0];

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [7:0]          tx_q, tx_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                sda_pull_q, sda_pull_d;
  logic                busy_q, busy_d;
  logic                fall_d1_q;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          reg_data_q;
  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic [7:0]          byte_in;

  assign byte_in = {shift_q, filt_q[1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_pull_d  = sda_pull_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      sda_pull_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_REG_IDX, S_WRITE_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDRESS[7:1]) begin
                  busy_d = 1'b1;
                  rw_d   = byte_in[0];
                end else begin
                  state_d   = S_IGNORE;
                  bit_cnt_d = '0;
                end
              end else if (state_q == S_REG_IDX) begin
                ptr_d = byte_in[ADDR_W-1:0];
              end else begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_q + ADDR_W'(1);
              end
            end
          end else if (fall_d1_q && bit_cnt_q == 4'd8) begin
            sda_pull_d = 1'b1;
            bit_cnt_d  = 4'd9;
          end else if (fall_d1_q && bit_cnt_q == 4'd9) begin
            // End of the ACK clock: release, and for a read put bit 7 straight out.
            sda_pull_d = 1'b0;
            bit_cnt_d  = '0;
            if (state_q == S_ADDR && rw_q) begin
              state_d    = S_READ_DATA;
              tx_d       = mem_q[ptr_q];
              sda_pull_d = ~mem_q[ptr_q][7];
            end else if (state_q == S_ADDR) begin
              state_d = S_REG_IDX;
            end else begin
              state_d = S_WRITE_DATA;
            end
          end
        end
        S_READ_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = {tx_q[6:0], 1'b0};
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            if (filt_q[1]) begin
              state_d    = S_IGNORE;
              sda_pull_d = 1'b0;
              bit_cnt_d  = '0;
            end else begin
              ptr_d     = ptr_q + ADDR_W'(1);
              bit_cnt_d = 4'd9;
            end
          end else if (fall_d1_q) begin
            if (bit_cnt_q < 4'd8) begin
              sda_pull_d = ~tx_q[7];
            end else if (bit_cnt_q == 4'd8) begin
              sda_pull_d = 1'b0;
            end else begin
              tx_d       = mem_q[ptr_q];
              sda_pull_d = ~mem_q[ptr_q][7];
              bit_cnt_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_pull_q  <= 1'b0;
      busy_q      <= 1'b0;
      fall_d1_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_pull_q  <= sda_pull_d;
      busy_q      <= busy_d;
      fall_d1_q   <= scl_fall;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
      // Write-first: a same-cycle bus write to the fabric address is returned directly.
      reg_data_q  <= (mem_we && ptr_q == REG_ADDR) ? byte_in : mem_q[REG_ADDR];
    end
  end

  assign bus.sda_pull = sda_pull_q;
  assign REG_DATA     = reg_data_q;
  assign WR_STROBE    = wr_strobe_q;
  assign WR_ADDR      = wr_addr_q;
  assign WR_DATA      = wr_data_q;
  assign flagBusy     = busy_q;
  assign dbg_state_o  = state_q;
endmodule
